// File: rtl/riscv_mc_controller_pkg.sv
// Shared definitions for the multicycle main controller: opcodes, FSM state
// encoding, ALU operation codes and datapath mux select codes. The ALU decoder
// uses the same alu_op_t codes.
package riscv_mc_controller_pkg;

  // Supported major opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // 4-bit state encoding, 11 states
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_A_PC    = 2'b00,
    SRC_A_OLDPC = 2'b01,
    SRC_A_RS1   = 2'b10
  } src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_READDATA  = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  // Per-state control word; branch and pc_update are combined into pc_write
  // together with the ALU zero flag.
  typedef struct packed {
    alu_op_t     alu_op;
    src_a_t      alu_src_a;
    src_b_t      alu_src_b;
    result_src_t result_src;
    logic        adr_src;
    logic        ir_write;
    logic        pc_update;
    logic        branch;
    logic        reg_write;
    logic        mem_write;
    logic        instr_done;
    logic        illegal_instr;
  } ctrl_t;

  // Control word with every enable low and the muxes steered as in FETCH.
  function automatic ctrl_t fetch_idle_ctrl();
    ctrl_t c;
    c               = '0;
    c.alu_op        = ALU_ADD;
    c.alu_src_a     = SRC_A_PC;
    c.alu_src_b     = SRC_B_FOUR;
    c.result_src    = RES_ALURESULT;
    c.adr_src       = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/riscv_mc_controller_if.sv
// Control bus between the multicycle controller and the datapath.
// master: the controller (drives enables/selects, receives opcode and status).
// slave:  the datapath (drives opcode and status, receives enables/selects).
interface riscv_mc_controller_if;
  import riscv_mc_controller_pkg::*;

  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;

  alu_op_t     alu_op;
  src_a_t      alu_src_a;
  src_b_t      alu_src_b;
  result_src_t result_src;
  logic        adr_src;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic        mem_write;
  logic        instr_done;
  logic        illegal_instr;

  modport master (
    input  opcode, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, result_src, adr_src,
           ir_write, pc_write, reg_write, mem_write,
           instr_done, illegal_instr
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, result_src, adr_src,
           ir_write, pc_write, reg_write, mem_write,
           instr_done, illegal_instr
  );

endinterface

// File: rtl/riscv_mc_controller.sv
// Multicycle main-control FSM. Sequences FETCH/DECODE/EXECUTE/MEM/WB for each
// instruction, stalls on memory accesses until mem_ready, flags unsupported
// opcodes and counts retired instructions.
module riscv_mc_controller
  import riscv_mc_controller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  riscv_mc_controller_if.master bus,
  output logic [CNT_W-1:0]     retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state;
  ctrl_t  ctrl;

  // State register and next-state selection; opcode is only consulted in
  // DECODE and MEMADR, where the instruction register holds it stable.
  // NOTE: sequential state is assigned with <= so every register samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      unique case (state)
        S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          unique case (bus.opcode)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXECR;
            OP_ITYPE:          state <= S_EXECI;
            OP_BRANCH:         state <= S_BEQ;
            OP_JAL:            state <= S_JAL;
            default:           state <= S_FETCH;
          endcase
        end
        S_MEMADR:   state <= bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (bus.mem_ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_JAL:      state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BEQ:      state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Output decode from the state register; reset forces every enable low and
  // steers the muxes as in FETCH so an aborted instruction writes nothing.
  // NOTE: ctrl gets a full default before the case so no path leaves a field
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ctrl = '0;
    if (reset) begin
      ctrl = fetch_idle_ctrl();
    end else begin
      unique case (state)
        S_FETCH: begin
          ctrl           = fetch_idle_ctrl();
          ctrl.ir_write  = bus.mem_ready;
          ctrl.pc_update = bus.mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_a = SRC_A_OLDPC;
          ctrl.alu_src_b = SRC_B_IMM;
          unique case (bus.opcode)
            OP_LOAD, OP_STORE, OP_RTYPE,
            OP_ITYPE, OP_BRANCH, OP_JAL: ctrl.illegal_instr = 1'b0;
            default:                     ctrl.illegal_instr = 1'b1;
          endcase
        end
        S_MEMADR: begin
          ctrl.alu_src_a = SRC_A_RS1;
          ctrl.alu_src_b = SRC_B_IMM;
        end
        S_MEMREAD: begin
          ctrl.result_src = RES_ALUOUT;
          ctrl.adr_src    = 1'b1;
        end
        S_MEMWB: begin
          ctrl.result_src = RES_READDATA;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          ctrl.result_src = RES_ALUOUT;
          ctrl.adr_src    = 1'b1;
          ctrl.mem_write  = 1'b1;
          ctrl.instr_done = bus.mem_ready;
        end
        S_EXECR: begin
          ctrl.alu_src_a = SRC_A_RS1;
          ctrl.alu_src_b = SRC_B_RS2;
          ctrl.alu_op    = ALU_FUNCT;
        end
        S_EXECI: begin
          ctrl.alu_src_a = SRC_A_RS1;
          ctrl.alu_src_b = SRC_B_IMM;
          ctrl.alu_op    = ALU_FUNCT;
        end
        S_JAL: begin
          ctrl.alu_src_a  = SRC_A_OLDPC;
          ctrl.alu_src_b  = SRC_B_FOUR;
          ctrl.result_src = RES_ALUOUT;
          ctrl.pc_update  = 1'b1;
        end
        S_ALUWB: begin
          ctrl.result_src = RES_ALUOUT;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_BEQ: begin
          ctrl.alu_src_a  = SRC_A_RS1;
          ctrl.alu_src_b  = SRC_B_RS2;
          ctrl.alu_op     = ALU_SUB;
          ctrl.result_src = RES_ALUOUT;
          ctrl.branch     = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        default: ctrl = fetch_idle_ctrl();
      endcase
    end
  end

  // Retired-instruction counter, wraps modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired <= '0;
    end else if (ctrl.instr_done) begin
      retired <= retired + CNT_ONE;
    end
  end

  assign bus.alu_op        = ctrl.alu_op;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.result_src    = ctrl.result_src;
  assign bus.adr_src       = ctrl.adr_src;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.pc_write      = ctrl.pc_update | (ctrl.branch & bus.zero);
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.instr_done    = ctrl.instr_done;
  assign bus.illegal_instr = ctrl.illegal_instr;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Self-checking bench for riscv_mc_controller: a per-cycle vector table with
// expected outputs feeding a scoreboard queue, plus a stalled-load latency run.
module tb_riscv_mc_controller;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] ILL0 = 7'b0000000;
  localparam logic [6:0] ILL1 = 7'b1110011;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       instr_done;
    logic       illegal_instr;
  } outs_t;

  typedef struct {
    logic        rst;
    logic [6:0]  opc;
    logic        zero;
    logic        mr;
    outs_t       exp;
    logic [31:0] exp_ret;
  } vec_t;

  typedef struct {
    outs_t       o;
    logic [31:0] r;
  } sb_t;

  logic        clk;
  logic        reset;
  logic [31:0] retired;

  riscv_mc_controller_if bus ();

  riscv_mc_controller #(.CNT_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .retired (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests_run;
  int          tests_failed;
  vec_t        vecs[$];
  sb_t         sb[$];
  logic [31:0] model_ret;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected control words, written from the state descriptions.
  function automatic outs_t o_fetch(input logic mr);
    outs_t o = '0;
    o.src_b = 2'b10; o.result_src = 2'b10;
    o.ir_write = mr; o.pc_write = mr;
    return o;
  endfunction
  function automatic outs_t o_decode(input logic ill);
    outs_t o = '0;
    o.src_a = 2'b01; o.src_b = 2'b01; o.illegal_instr = ill;
    return o;
  endfunction
  function automatic outs_t o_memadr();
    outs_t o = '0;
    o.src_a = 2'b10; o.src_b = 2'b01;
    return o;
  endfunction
  function automatic outs_t o_memread();
    outs_t o = '0;
    o.adr_src = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_memwb();
    outs_t o = '0;
    o.result_src = 2'b01; o.reg_write = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_memwrite(input logic mr);
    outs_t o = '0;
    o.adr_src = 1'b1; o.mem_write = 1'b1; o.instr_done = mr;
    return o;
  endfunction
  function automatic outs_t o_exec(input logic imm);
    outs_t o = '0;
    o.alu_op = 2'b10; o.src_a = 2'b10; o.src_b = imm ? 2'b01 : 2'b00;
    return o;
  endfunction
  function automatic outs_t o_jal();
    outs_t o = '0;
    o.src_a = 2'b01; o.src_b = 2'b10; o.pc_write = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_aluwb();
    outs_t o = '0;
    o.reg_write = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_beq(input logic z);
    outs_t o = '0;
    o.alu_op = 2'b01; o.src_a = 2'b10; o.pc_write = z; o.instr_done = 1'b1;
    return o;
  endfunction

  // Append one cycle to the table; the retire model advances alongside.
  task automatic add(input logic rst, input logic [6:0] opc, input logic z,
                     input logic mr, input outs_t e);
    vec_t v;
    v.rst = rst; v.opc = opc; v.zero = z; v.mr = mr; v.exp = e;
    v.exp_ret = model_ret;
    vecs.push_back(v);
    if (rst) model_ret = '0;
    else if (e.instr_done) model_ret = model_ret + 32'd1;
  endtask

  function automatic outs_t sample_outs();
    outs_t a;
    a.alu_op        = bus.alu_op;
    a.src_a         = bus.alu_src_a;
    a.src_b         = bus.alu_src_b;
    a.result_src    = bus.result_src;
    a.adr_src       = bus.adr_src;
    a.ir_write      = bus.ir_write;
    a.pc_write      = bus.pc_write;
    a.reg_write     = bus.reg_write;
    a.mem_write     = bus.mem_write;
    a.instr_done    = bus.instr_done;
    a.illegal_instr = bus.illegal_instr;
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t  e;
    int   cycles;
    logic got;

    tests_run = 0;
    tests_failed = 0;
    model_ret = '0;

    // lw, no stalls: 5 cycles, writes only in MEMWB
    add(0, LW, 0, 1, o_fetch(1));
    add(0, LW, 0, 1, o_decode(0));
    add(0, LW, 0, 1, o_memadr());
    add(0, LW, 0, 1, o_memread());
    add(0, LW, 0, 1, o_memwb());
    // lw stalled in MEMREAD, then reset held 2 cycles
    add(0, LW, 0, 1, o_fetch(1));
    add(0, LW, 0, 1, o_decode(0));
    add(0, LW, 0, 1, o_memadr());
    add(0, LW, 0, 0, o_memread());
    add(0, LW, 0, 0, o_memread());
    add(1, LW, 0, 0, o_fetch(0));
    add(1, LW, 0, 1, o_fetch(0));
    // sw with 3 stall cycles in MEMWRITE
    add(0, SW, 0, 1, o_fetch(1));
    add(0, SW, 0, 1, o_decode(0));
    add(0, SW, 0, 1, o_memadr());
    add(0, SW, 0, 0, o_memwrite(0));
    add(0, SW, 0, 0, o_memwrite(0));
    add(0, SW, 0, 0, o_memwrite(0));
    add(0, SW, 0, 1, o_memwrite(1));
    // beq taken, then not taken
    add(0, BEQ, 1, 1, o_fetch(1));
    add(0, BEQ, 1, 1, o_decode(0));
    add(0, BEQ, 1, 1, o_beq(1));
    add(0, BEQ, 1, 1, o_fetch(1));
    add(0, BEQ, 1, 1, o_decode(0));
    add(0, BEQ, 0, 1, o_beq(0));
    // R-type, I-type, jal
    add(0, RT, 0, 1, o_fetch(1));
    add(0, RT, 0, 1, o_decode(0));
    add(0, RT, 0, 1, o_exec(0));
    add(0, RT, 0, 1, o_aluwb());
    add(0, IT, 0, 1, o_fetch(1));
    add(0, IT, 0, 1, o_decode(0));
    add(0, IT, 0, 1, o_exec(1));
    add(0, IT, 0, 1, o_aluwb());
    add(0, JAL, 0, 1, o_fetch(1));
    add(0, JAL, 0, 1, o_decode(0));
    add(0, JAL, 0, 1, o_jal());
    add(0, JAL, 0, 1, o_aluwb());
    // illegal opcodes and a 5-cycle fetch stall
    add(0, ILL0, 0, 1, o_fetch(1));
    add(0, ILL0, 0, 1, o_decode(1));
    for (int k = 0; k < 5; k++) add(0, ILL0, 0, 0, o_fetch(0));
    add(0, ILL1, 1, 1, o_fetch(1));
    add(0, ILL1, 1, 1, o_decode(1));
    add(0, LW, 0, 1, o_fetch(1));
    add(1, LW, 0, 1, o_fetch(0));

    // power-on reset
    reset = 1'b1;
    bus.opcode = LW;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset         = vecs[i].rst;
      bus.opcode    = vecs[i].opc;
      bus.zero      = vecs[i].zero;
      bus.mem_ready = vecs[i].mr;
      sb.push_back('{o: vecs[i].exp, r: vecs[i].exp_ret});
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("row%0d_outs", i), 64'(sample_outs()), 64'(e.o));
      check($sformatf("row%0d_retired", i), 64'(retired), 64'(e.r));
    end

    // Stalled lw from a clean reset: 2 fetch stalls + 5 cycles = done on cycle 7
    got = 1'b0;
    cycles = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk);
      #1;
      reset         = 1'b0;
      bus.opcode    = LW;
      bus.zero      = 1'b0;
      bus.mem_ready = (c >= 2);
      @(negedge clk);
      if (bus.instr_done === 1'b1) begin
        got = 1'b1;
        cycles = c + 1;
      end
    end
    check("lw_stall_latency", 64'(cycles), 64'd7);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lw_stall_retired", 64'(retired), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
